// File: rtl/rst_seq_pkg.sv
// Shared definitions for the staged reset sequencer: state encoding and
// the index-width helper used to size the stage index and err_stg port.
package rst_seq_pkg;

  typedef enum logic [2:0] {
    ST_RESET    = 3'd0,
    ST_HOLD     = 3'd1,
    ST_WAIT_RDY = 3'd2,
    ST_RUN      = 3'd3,
    ST_ERR      = 3'd4
  } state_e;

  // Width of a stage index; never narrower than one bit.
  function automatic int idx_w(input int n);
    int w;
    w = $clog2(n);
    if (w < 1) begin
      w = 1;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage

// File: rtl/rst_seq.sv
// Staged reset sequencer: releases NUM_STG reset domains in index order,
// each after a hold time, then waits for its ready ack with a timeout.
module rst_seq
  import rst_seq_pkg::*;
#(
  parameter  int NUM_STG  = 4,
  parameter  int HOLD_CYC = 3,
  parameter  int TO_CYC   = 255,
  parameter  int CNT_W    = 8,
  localparam int IDX_W    = idx_w(NUM_STG)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sw_rst_req,
  input  logic [NUM_STG-1:0] stg_rdy,
  output logic [NUM_STG-1:0] stg_rst,
  output logic               all_rdy,
  output logic               busy,
  output logic               err,
  output logic [IDX_W-1:0]   err_stg
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TO_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_STG - 1);

  state_e           state_r;
  logic [IDX_W-1:0] idx_r;
  logic [CNT_W-1:0] cnt_r;
  logic [IDX_W-1:0] low_zero_s;
  logic             cur_rdy_s;

  // Lowest stage whose ready is low, reported when RUN loses a stage.
  always_comb begin
    low_zero_s = '0;
    for (int i = NUM_STG - 1; i >= 0; i--) begin
      if (!stg_rdy[i]) begin
        low_zero_s = IDX_W'(i);
      end else begin
        low_zero_s = low_zero_s;
      end
    end
  end

  // Ready of the stage currently being waited on; later stages are ignored.
  always_comb begin
    cur_rdy_s = 1'b0;
    for (int i = 0; i < NUM_STG; i++) begin
      if (idx_r == IDX_W'(i)) begin
        cur_rdy_s = stg_rdy[i];
      end else begin
        cur_rdy_s = cur_rdy_s;
      end
    end
  end

  // Sequencer FSM with registered outputs; a software request acts as reset.
  always_ff @(posedge clk) begin
    if (!rst_n || sw_rst_req) begin
      state_r <= ST_RESET;
      stg_rst <= '1;
      idx_r   <= '0;
      cnt_r   <= '0;
      all_rdy <= 1'b0;
      busy    <= 1'b1;
      err     <= 1'b0;
      err_stg <= '0;
    end else begin
      case (state_r)
        ST_RESET: begin
          state_r <= ST_HOLD;
          cnt_r   <= '0;
          stg_rst <= '1;
          busy    <= 1'b1;
        end
        ST_HOLD: begin
          if (cnt_r == HOLD_LAST) begin
            // Lower stages are already released, so order is preserved.
            stg_rst[idx_r] <= 1'b0;
            cnt_r          <= '0;
            state_r        <= ST_WAIT_RDY;
          end else begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        ST_WAIT_RDY: begin
          // Ready wins over a timeout landing on the same edge.
          if (cur_rdy_s && (idx_r == IDX_LAST)) begin
            state_r <= ST_RUN;
            stg_rst <= '0;
            all_rdy <= 1'b1;
            busy    <= 1'b0;
          end else if (cur_rdy_s) begin
            idx_r   <= idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
            cnt_r   <= '0;
            state_r <= ST_HOLD;
          end else if (cnt_r == TO_LAST) begin
            state_r <= ST_ERR;
            stg_rst <= '1;
            busy    <= 1'b0;
            err     <= 1'b1;
            err_stg <= idx_r;
          end else begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        ST_RUN: begin
          if (stg_rdy != {NUM_STG{1'b1}}) begin
            state_r <= ST_ERR;
            stg_rst <= '1;
            all_rdy <= 1'b0;
            busy    <= 1'b0;
            err     <= 1'b1;
            err_stg <= low_zero_s;
          end else begin
            stg_rst <= '0;
          end
        end
        ST_ERR: begin
          stg_rst <= '1;
          all_rdy <= 1'b0;
          busy    <= 1'b0;
          err     <= 1'b1;
        end
        default: begin
          // Unreachable encoding: fall back to a full restart.
          state_r <= ST_RESET;
          stg_rst <= '1;
          idx_r   <= '0;
          cnt_r   <= '0;
          all_rdy <= 1'b0;
          busy    <= 1'b1;
          err     <= 1'b0;
          err_stg <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rst_seq.sv
// Directed bench for rst_seq: a per-edge vector table for the baseline run,
// plus hand-written sequences for delay, timeout and simultaneous events.
module tb_rst_seq;

  typedef struct {
    logic       rst_n;
    logic       sw;
    logic [3:0] rdy;
    logic [3:0] stg;
    logic       all_rdy;
    logic       busy;
    logic       err;
    logic [1:0] es;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n, sw_rst_req, rst_n_t, sw_t;
  logic [3:0] stg_rdy, stg_rdy_t;
  logic [3:0] stg_rst, stg_rst_t;
  logic       all_rdy, busy, err, all_rdy_t, busy_t, err_t;
  logic [1:0] err_stg, err_stg_t;

  int total = 0;
  int bad   = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  rst_seq #(.NUM_STG(4), .HOLD_CYC(3), .TO_CYC(255), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .sw_rst_req(sw_rst_req), .stg_rdy(stg_rdy),
    .stg_rst(stg_rst), .all_rdy(all_rdy), .busy(busy), .err(err), .err_stg(err_stg)
  );

  rst_seq #(.NUM_STG(4), .HOLD_CYC(3), .TO_CYC(5), .CNT_W(8)) u_dut_to (
    .clk(clk), .rst_n(rst_n_t), .sw_rst_req(sw_t), .stg_rdy(stg_rdy_t),
    .stg_rst(stg_rst_t), .all_rdy(all_rdy_t), .busy(busy_t), .err(err_t), .err_stg(err_stg_t)
  );

  always @(posedge all_rdy) $display("%0t: Reset sequence complete", $time);

  function automatic vec_t mk(input logic r, input logic s, input logic [3:0] rd,
                              input logic [3:0] st, input logic a, input logic b,
                              input logic e, input logic [1:0] es);
    vec_t v;
    v.rst_n = r; v.sw = s; v.rdy = rd; v.stg = st;
    v.all_rdy = a; v.busy = b; v.err = e; v.es = es;
    return v;
  endfunction

  // Baseline stg_rst after k edges counted from the reset edge (ready tied high).
  function automatic logic [3:0] base_stg(input int k);
    if (k < 4)       return 4'b1111;
    else if (k < 8)  return 4'b1110;
    else if (k < 12) return 4'b1100;
    else if (k < 16) return 4'b1000;
    else             return 4'b0000;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic chk_main(input string name, input logic [3:0] st, input logic a,
                          input logic b, input logic e, input logic [1:0] es);
    chk({name, ".stg_rst"}, {28'd0, stg_rst}, {28'd0, st});
    chk({name, ".all_rdy"}, {31'd0, all_rdy}, {31'd0, a});
    chk({name, ".busy"},    {31'd0, busy},    {31'd0, b});
    chk({name, ".err"},     {31'd0, err},     {31'd0, e});
    chk({name, ".err_stg"}, {30'd0, err_stg}, {30'd0, es});
  endtask

  task automatic chk_to(input string name, input logic [3:0] st, input logic a,
                        input logic b, input logic e, input logic [1:0] es);
    chk({name, ".stg_rst"}, {28'd0, stg_rst_t}, {28'd0, st});
    chk({name, ".all_rdy"}, {31'd0, all_rdy_t}, {31'd0, a});
    chk({name, ".busy"},    {31'd0, busy_t},    {31'd0, b});
    chk({name, ".err"},     {31'd0, err_t},     {31'd0, e});
    chk({name, ".err_stg"}, {30'd0, err_stg_t}, {30'd0, es});
  endtask

  // Reset the timeout instance, then run it to stage-1 WAIT_RDY with ready 0001.
  task automatic to_to_stage1();
    rst_n_t = 1'b0; sw_t = 1'b0; stg_rdy_t = 4'b0001;
    step();
    rst_n_t = 1'b1;
    repeat (8) step();
  endtask

  initial begin
    rst_n = 1'b0; sw_rst_req = 1'b0; stg_rdy = 4'b1111;
    rst_n_t = 1'b0; sw_t = 1'b0; stg_rdy_t = 4'b0000;

    // Baseline run, RUN drop to ERR, then software re-sequence.
    tbl.push_back(mk(1'b0, 1'b0, 4'b1111, 4'b1111, 1'b0, 1'b1, 1'b0, 2'd0));
    for (int k = 1; k <= 3; k++)   tbl.push_back(mk(1'b1, 1'b0, 4'b1111, 4'b1111, 1'b0, 1'b1, 1'b0, 2'd0));
    for (int k = 4; k <= 7; k++)   tbl.push_back(mk(1'b1, 1'b0, 4'b1111, 4'b1110, 1'b0, 1'b1, 1'b0, 2'd0));
    for (int k = 8; k <= 11; k++)  tbl.push_back(mk(1'b1, 1'b0, 4'b1111, 4'b1100, 1'b0, 1'b1, 1'b0, 2'd0));
    for (int k = 12; k <= 15; k++) tbl.push_back(mk(1'b1, 1'b0, 4'b1111, 4'b1000, 1'b0, 1'b1, 1'b0, 2'd0));
    tbl.push_back(mk(1'b1, 1'b0, 4'b1111, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd0));
    tbl.push_back(mk(1'b1, 1'b0, 4'b1111, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0));
    tbl.push_back(mk(1'b1, 1'b0, 4'b1111, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0));
    tbl.push_back(mk(1'b1, 1'b0, 4'b1011, 4'b1111, 1'b0, 1'b0, 1'b1, 2'd2));
    tbl.push_back(mk(1'b1, 1'b0, 4'b1111, 4'b1111, 1'b0, 1'b0, 1'b1, 2'd2));
    tbl.push_back(mk(1'b1, 1'b1, 4'b1111, 4'b1111, 1'b0, 1'b1, 1'b0, 2'd0));

    foreach (tbl[i]) begin
      rst_n = tbl[i].rst_n; sw_rst_req = tbl[i].sw; stg_rdy = tbl[i].rdy;
      step();
      chk_main($sformatf("vec%0d", i), tbl[i].stg, tbl[i].all_rdy, tbl[i].busy,
               tbl[i].err, tbl[i].es);
    end

    // Replay after the software request, counted from the request edge.
    sw_rst_req = 1'b0;
    for (int k = 1; k <= 18; k++) begin
      step();
      chk($sformatf("replay%0d.stg_rst", k), {28'd0, stg_rst}, {28'd0, base_stg(k)});
      chk($sformatf("replay%0d.all_rdy", k), {31'd0, all_rdy}, {31'd0, (k >= 17)});
    end
    stg_rdy = 4'b0101;
    step();
    chk_main("run_drop_lowest", 4'b1111, 1'b0, 1'b0, 1'b1, 2'd1);

    // Stage 2 ready arrives 10 edges late: stage 3 releases at edge 26, not 16.
    rst_n = 1'b0; stg_rdy = 4'b1011;
    step();
    rst_n = 1'b1;
    for (int k = 1; k <= 28; k++) begin
      stg_rdy = (k >= 23) ? 4'b1111 : 4'b1011;
      step();
      chk($sformatf("delay%0d.stg_rst", k), {28'd0, stg_rst},
          {28'd0, (k < 12) ? base_stg(k) : ((k < 26) ? 4'b1000 : 4'b0000)});
      chk($sformatf("delay%0d.err", k), {31'd0, err}, 32'd0);
    end
    chk("delay.all_rdy", {31'd0, all_rdy}, 32'd1);

    // rst_n asserted while waiting on stage 0.
    rst_n = 1'b0; stg_rdy = 4'b0000;
    step();
    rst_n = 1'b1;
    repeat (6) step();
    chk_main("midwait.pre", 4'b1110, 1'b0, 1'b1, 1'b0, 2'd0);
    rst_n = 1'b0;
    step();
    chk_main("midwait.rst", 4'b1111, 1'b0, 1'b1, 1'b0, 2'd0);

    // Stage 1 never ready with TO_CYC=5: released at edge 8, ERR at edge 13.
    to_to_stage1();
    chk_to("to.released", 4'b1100, 1'b0, 1'b1, 1'b0, 2'd0);
    repeat (4) step();
    chk_to("to.edge12", 4'b1100, 1'b0, 1'b1, 1'b0, 2'd0);
    step();
    chk_to("to.err", 4'b1111, 1'b0, 1'b0, 1'b1, 2'd1);
    repeat (3) step();
    chk_to("to.err_held", 4'b1111, 1'b0, 1'b0, 1'b1, 2'd1);

    // Software request on the timeout edge: RESET, not ERR.
    to_to_stage1();
    repeat (4) step();
    sw_t = 1'b1;
    step();
    chk_to("sw_vs_to", 4'b1111, 1'b0, 1'b1, 1'b0, 2'd0);
    sw_t = 1'b0;
    step();
    chk_to("sw_vs_to.next", 4'b1111, 1'b0, 1'b1, 1'b0, 2'd0);

    // Ready rising on the timeout edge advances to stage 2.
    to_to_stage1();
    repeat (4) step();
    stg_rdy_t = 4'b0011;
    step();
    chk_to("rdy_vs_to", 4'b1100, 1'b0, 1'b1, 1'b0, 2'd0);
    repeat (3) step();
    chk_to("rdy_vs_to.stage2", 4'b1000, 1'b0, 1'b1, 1'b0, 2'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
